// File: rtl/id_ex_stage.sv
// ID/EX pipeline register for the 5-stage MIPS pipeline.
// Captures decoded operands and control from ID, resolves RAW hazards by
// forwarding from EX/MEM and MEM/WB, detects load-use hazards and inserts
// bubbles on stall or branch flush.
module id_ex_stage #(
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,

    // Decode stage
    input  logic              id_valid,
    input  logic [4:0]        id_rs,
    input  logic [4:0]        id_rt,
    input  logic [4:0]        id_rd,
    input  logic [DATA_W-1:0] id_rs_data,
    input  logic [DATA_W-1:0] id_rt_data,
    input  logic [DATA_W-1:0] id_imm,
    input  logic [4:0]        id_shamt,
    input  logic [3:0]        id_ctrl_alu,
    input  logic              id_src_imm,
    input  logic              id_src_shamt,
    input  logic              id_reg_write,
    input  logic              id_mem_read,
    input  logic              id_mem_write,
    input  logic              id_mem_to_reg,

    // Branch/jump resolved taken
    input  logic              flush_ex,

    // EX/MEM forwarding source
    input  logic              exmem_reg_write,
    input  logic              exmem_mem_read,
    input  logic [4:0]        exmem_rd,
    input  logic [DATA_W-1:0] exmem_alu_out,

    // MEM/WB forwarding source (final writeback value)
    input  logic              memwb_reg_write,
    input  logic [4:0]        memwb_rd,
    input  logic [DATA_W-1:0] memwb_wdata,

    // Hazard and EX-stage outputs
    output logic              stall_id,
    output logic              ex_valid,
    output logic [DATA_W-1:0] ex_in1,
    output logic [DATA_W-1:0] ex_in2,
    output logic [3:0]        ex_ctrl_alu,
    output logic [DATA_W-1:0] ex_store_data,
    output logic [4:0]        ex_rd,
    output logic              ex_reg_write,
    output logic              ex_mem_read,
    output logic              ex_mem_write,
    output logic              ex_mem_to_reg
);

    localparam int unsigned REG_W  = 5;
    localparam int unsigned CTRL_W = 4;

    // Pipeline register state
    logic              valid_q,      valid_d;
    logic [REG_W-1:0]  rs_q,         rs_d;
    logic [REG_W-1:0]  rt_q,         rt_d;
    logic [REG_W-1:0]  rd_q,         rd_d;
    logic [DATA_W-1:0] rs_data_q,    rs_data_d;
    logic [DATA_W-1:0] rt_data_q,    rt_data_d;
    logic [DATA_W-1:0] imm_q,        imm_d;
    logic [REG_W-1:0]  shamt_q,      shamt_d;
    logic [CTRL_W-1:0] ctrl_alu_q,   ctrl_alu_d;
    logic              src_imm_q,    src_imm_d;
    logic              src_shamt_q,  src_shamt_d;
    logic              reg_write_q,  reg_write_d;
    logic              mem_read_q,   mem_read_d;
    logic              mem_write_q,  mem_write_d;
    logic              mem_to_reg_q, mem_to_reg_d;

    logic              load_use;
    logic              byp_rs;
    logic              byp_rt;
    logic [DATA_W-1:0] fwd_rs;
    logic [DATA_W-1:0] fwd_rt;

    // Load in EX whose destination is read by the instruction in ID.
    // Both rs and rt are checked even if the instruction only uses one.
    always_comb begin
        load_use = valid_q && mem_read_q && (rd_q != '0)
                   && ((rd_q == id_rs) || (rd_q == id_rt))
                   && id_valid && !flush_ex;
    end

    assign stall_id = load_use;

    // Writeback happening this cycle bypasses the register-file read at capture
    always_comb begin
        byp_rs = memwb_reg_write && (memwb_rd != '0) && (memwb_rd == id_rs);
        byp_rt = memwb_reg_write && (memwb_rd != '0) && (memwb_rd == id_rt);
    end

    // Next state: flush and stall both insert a zeroed bubble, flush first
    always_comb begin
        valid_d      = 1'b0;
        rs_d         = '0;
        rt_d         = '0;
        rd_d         = '0;
        rs_data_d    = '0;
        rt_data_d    = '0;
        imm_d        = '0;
        shamt_d      = '0;
        ctrl_alu_d   = '0;
        src_imm_d    = 1'b0;
        src_shamt_d  = 1'b0;
        reg_write_d  = 1'b0;
        mem_read_d   = 1'b0;
        mem_write_d  = 1'b0;
        mem_to_reg_d = 1'b0;
        if (!flush_ex && !load_use) begin
            valid_d      = id_valid;
            rs_d         = id_rs;
            rt_d         = id_rt;
            rd_d         = id_rd;
            rs_data_d    = byp_rs ? memwb_wdata : id_rs_data;
            rt_data_d    = byp_rt ? memwb_wdata : id_rt_data;
            imm_d        = id_imm;
            shamt_d      = id_shamt;
            ctrl_alu_d   = id_ctrl_alu;
            src_imm_d    = id_src_imm;
            src_shamt_d  = id_src_shamt;
            reg_write_d  = id_reg_write;
            mem_read_d   = id_mem_read;
            mem_write_d  = id_mem_write;
            mem_to_reg_d = id_mem_to_reg;
        end
    end

    // ID/EX register, cleared asynchronously so the pipeline empties at once
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q      <= 1'b0;
            rs_q         <= '0;
            rt_q         <= '0;
            rd_q         <= '0;
            rs_data_q    <= '0;
            rt_data_q    <= '0;
            imm_q        <= '0;
            shamt_q      <= '0;
            ctrl_alu_q   <= '0;
            src_imm_q    <= 1'b0;
            src_shamt_q  <= 1'b0;
            reg_write_q  <= 1'b0;
            mem_read_q   <= 1'b0;
            mem_write_q  <= 1'b0;
            mem_to_reg_q <= 1'b0;
        end else begin
            valid_q      <= valid_d;
            rs_q         <= rs_d;
            rt_q         <= rt_d;
            rd_q         <= rd_d;
            rs_data_q    <= rs_data_d;
            rt_data_q    <= rt_data_d;
            imm_q        <= imm_d;
            shamt_q      <= shamt_d;
            ctrl_alu_q   <= ctrl_alu_d;
            src_imm_q    <= src_imm_d;
            src_shamt_q  <= src_shamt_d;
            reg_write_q  <= reg_write_d;
            mem_read_q   <= mem_read_d;
            mem_write_q  <= mem_write_d;
            mem_to_reg_q <= mem_to_reg_d;
        end
    end

    // Operand forwarding: EX/MEM (non-load) beats MEM/WB; $0 never forwarded
    always_comb begin
        fwd_rs = rs_data_q;
        if (exmem_reg_write && !exmem_mem_read && (exmem_rd != '0) && (exmem_rd == rs_q)) begin
            fwd_rs = exmem_alu_out;
        end else if (memwb_reg_write && (memwb_rd != '0) && (memwb_rd == rs_q)) begin
            fwd_rs = memwb_wdata;
        end

        fwd_rt = rt_data_q;
        if (exmem_reg_write && !exmem_mem_read && (exmem_rd != '0) && (exmem_rd == rt_q)) begin
            fwd_rt = exmem_alu_out;
        end else if (memwb_reg_write && (memwb_rd != '0) && (memwb_rd == rt_q)) begin
            fwd_rt = memwb_wdata;
        end
    end

    // ALU operand select; shifts take the count on in1 and the value on in2
    always_comb begin
        ex_in1        = src_shamt_q ? DATA_W'(shamt_q) : fwd_rs;
        ex_in2        = src_imm_q ? imm_q : fwd_rt;
        ex_store_data = fwd_rt;
    end

    assign ex_valid      = valid_q;
    assign ex_ctrl_alu   = ctrl_alu_q;
    assign ex_rd         = rd_q;
    assign ex_reg_write  = reg_write_q;
    assign ex_mem_read   = mem_read_q;
    assign ex_mem_write  = mem_write_q;
    assign ex_mem_to_reg = mem_to_reg_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed testbench for id_ex_stage.
module tb_id_ex_stage;

    localparam int unsigned DATA_W = 32;

    logic              clk;
    logic              rst_n;
    logic              id_valid;
    logic [4:0]        id_rs, id_rt, id_rd, id_shamt;
    logic [DATA_W-1:0] id_rs_data, id_rt_data, id_imm;
    logic [3:0]        id_ctrl_alu;
    logic              id_src_imm, id_src_shamt;
    logic              id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg;
    logic              flush_ex;
    logic              exmem_reg_write, exmem_mem_read;
    logic [4:0]        exmem_rd;
    logic [DATA_W-1:0] exmem_alu_out;
    logic              memwb_reg_write;
    logic [4:0]        memwb_rd;
    logic [DATA_W-1:0] memwb_wdata;
    logic              stall_id, ex_valid;
    logic [DATA_W-1:0] ex_in1, ex_in2, ex_store_data;
    logic [3:0]        ex_ctrl_alu;
    logic [4:0]        ex_rd;
    logic              ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg;

    int passed;
    int total;

    id_ex_stage #(.DATA_W(DATA_W)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .id_valid        (id_valid),
        .id_rs           (id_rs),
        .id_rt           (id_rt),
        .id_rd           (id_rd),
        .id_rs_data      (id_rs_data),
        .id_rt_data      (id_rt_data),
        .id_imm          (id_imm),
        .id_shamt        (id_shamt),
        .id_ctrl_alu     (id_ctrl_alu),
        .id_src_imm      (id_src_imm),
        .id_src_shamt    (id_src_shamt),
        .id_reg_write    (id_reg_write),
        .id_mem_read     (id_mem_read),
        .id_mem_write    (id_mem_write),
        .id_mem_to_reg   (id_mem_to_reg),
        .flush_ex        (flush_ex),
        .exmem_reg_write (exmem_reg_write),
        .exmem_mem_read  (exmem_mem_read),
        .exmem_rd        (exmem_rd),
        .exmem_alu_out   (exmem_alu_out),
        .memwb_reg_write (memwb_reg_write),
        .memwb_rd        (memwb_rd),
        .memwb_wdata     (memwb_wdata),
        .stall_id        (stall_id),
        .ex_valid        (ex_valid),
        .ex_in1          (ex_in1),
        .ex_in2          (ex_in2),
        .ex_ctrl_alu     (ex_ctrl_alu),
        .ex_store_data   (ex_store_data),
        .ex_rd           (ex_rd),
        .ex_reg_write    (ex_reg_write),
        .ex_mem_read     (ex_mem_read),
        .ex_mem_write    (ex_mem_write),
        .ex_mem_to_reg   (ex_mem_to_reg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive every input to its idle value
    task automatic clear_inputs();
        id_valid = 0; id_rs = 0; id_rt = 0; id_rd = 0; id_shamt = 0;
        id_rs_data = 0; id_rt_data = 0; id_imm = 0; id_ctrl_alu = 0;
        id_src_imm = 0; id_src_shamt = 0;
        id_reg_write = 0; id_mem_read = 0; id_mem_write = 0; id_mem_to_reg = 0;
        flush_ex = 0;
        exmem_reg_write = 0; exmem_mem_read = 0; exmem_rd = 0; exmem_alu_out = 0;
        memwb_reg_write = 0; memwb_rd = 0; memwb_wdata = 0;
    endtask

    // One clock: capture on posedge, return at the following negedge
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Put lw $6 into EX
    task automatic load_lw6();
        clear_inputs();
        id_valid = 1; id_rs = 2; id_rd = 6; id_imm = 32'd4; id_src_imm = 1;
        id_reg_write = 1; id_mem_read = 1; id_mem_to_reg = 1;
        step();
    endtask

    task automatic test_reset();
        load_lw6();
        total++;
        if (ex_mem_read !== 1'b1) $display("FAIL pre_reset_load: ex_mem_read=%0b exp 1", ex_mem_read);
        else passed++;
        // add $7,$6,$1 in ID -> load-use visible before reset
        id_mem_read = 0; id_mem_to_reg = 0; id_src_imm = 0; id_imm = 0;
        id_rs = 6; id_rt = 1; id_rd = 7; id_ctrl_alu = 4'b0001;
        #1;
        total++;
        if (stall_id !== 1'b1) $display("FAIL pre_reset_stall: stall_id=%0b exp 1", stall_id);
        else passed++;
        #1 rst_n = 0;
        #1;
        total++;
        if ({ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg, stall_id} !== 6'b0)
            $display("FAIL reset_ctrl: valid/ctl/stall=%b exp 000000",
                     {ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg, stall_id});
        else passed++;
        total++;
        if ({ex_in1, ex_in2, ex_store_data} !== 96'h0)
            $display("FAIL reset_data: in1=%h in2=%h st=%h exp 0", ex_in1, ex_in2, ex_store_data);
        else passed++;
        total++;
        if ({ex_ctrl_alu, ex_rd} !== 9'h0)
            $display("FAIL reset_alu_rd: ctrl=%h rd=%0d exp 0", ex_ctrl_alu, ex_rd);
        else passed++;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1;
        clear_inputs();
        step();
    endtask

    task automatic test_exmem_fwd();
        clear_inputs();
        // sub $4,$3,$1 with stale $3 from the register file
        id_valid = 1; id_rs = 3; id_rt = 1; id_rd = 4;
        id_rs_data = 32'hDEAD; id_rt_data = 32'h5; id_ctrl_alu = 4'b0001; id_reg_write = 1;
        step();
        total++;
        if (ex_in1 !== 32'hDEAD) $display("FAIL exmem_nofwd_in1: got %h exp 0000dead", ex_in1);
        else passed++;
        // add $3,$1,$2 result sitting in EX/MEM
        exmem_reg_write = 1; exmem_rd = 3; exmem_alu_out = 32'h10;
        #1;
        total++;
        if (ex_in1 !== 32'h10) $display("FAIL exmem_fwd_in1: got %h exp 00000010", ex_in1);
        else passed++;
        total++;
        if (ex_ctrl_alu !== 4'b0001 || ex_in2 !== 32'h5 || ex_rd !== 5'd4)
            $display("FAIL exmem_fwd_misc: ctrl=%h in2=%h rd=%0d exp 1/00000005/4", ex_ctrl_alu, ex_in2, ex_rd);
        else passed++;
    endtask

    task automatic test_fwd_priority();
        clear_inputs();
        id_valid = 1; id_rt = 5; id_rt_data = 32'h77; id_rd = 8; id_reg_write = 1;
        step();
        id_valid = 0; id_rt = 0;
        exmem_reg_write = 1; exmem_rd = 5; exmem_alu_out = 32'hA;
        memwb_reg_write = 1; memwb_rd = 5; memwb_wdata = 32'hB;
        #1;
        total++;
        if (ex_in2 !== 32'hA || ex_store_data !== 32'hA)
            $display("FAIL prio_exmem: in2=%h st=%h exp 0000000a", ex_in2, ex_store_data);
        else passed++;
        exmem_reg_write = 0;
        #1;
        total++;
        if (ex_in2 !== 32'hB) $display("FAIL prio_memwb: in2=%h exp 0000000b", ex_in2);
        else passed++;
        // a load in EX/MEM has no value yet, so MEM/WB must be used
        exmem_reg_write = 1; exmem_mem_read = 1;
        #1;
        total++;
        if (ex_in2 !== 32'hB) $display("FAIL prio_exmem_load: in2=%h exp 0000000b", ex_in2);
        else passed++;
        memwb_reg_write = 0;
        #1;
        total++;
        if (ex_in2 !== 32'h77) $display("FAIL prio_none: in2=%h exp 00000077", ex_in2);
        else passed++;
    endtask

    task automatic test_load_use();
        load_lw6();
        id_mem_read = 0; id_mem_to_reg = 0; id_src_imm = 0; id_imm = 0;
        id_rs = 6; id_rt = 1; id_rd = 7; id_rs_data = 32'hBAD; id_rt_data = 32'h3;
        id_ctrl_alu = 4'b0001;
        #1;
        total++;
        if (stall_id !== 1'b1) $display("FAIL lu_stall: stall_id=%0b exp 1", stall_id);
        else passed++;
        step();
        total++;
        if (ex_valid !== 1'b0 || ex_reg_write !== 1'b0 || ex_rd !== 5'd0 || stall_id !== 1'b0)
            $display("FAIL lu_bubble: valid=%0b rw=%0b rd=%0d stall=%0b exp 0/0/0/0",
                     ex_valid, ex_reg_write, ex_rd, stall_id);
        else passed++;
        // load now in EX/MEM
        exmem_reg_write = 1; exmem_mem_read = 1; exmem_rd = 6; exmem_alu_out = 32'h999;
        step();
        // load now in MEM/WB, bubble in EX/MEM
        exmem_reg_write = 0; exmem_mem_read = 0; exmem_rd = 0;
        memwb_reg_write = 1; memwb_rd = 6; memwb_wdata = 32'h1234;
        #1;
        total++;
        if (ex_in1 !== 32'h1234 || ex_in2 !== 32'h3)
            $display("FAIL lu_memwb_fwd: in1=%h in2=%h exp 00001234/00000003", ex_in1, ex_in2);
        else passed++;
        total++;
        if (ex_valid !== 1'b1 || ex_rd !== 5'd7 || stall_id !== 1'b0)
            $display("FAIL lu_after: valid=%0b rd=%0d stall=%0b exp 1/7/0", ex_valid, ex_rd, stall_id);
        else passed++;
    endtask

    task automatic test_flush_over_stall();
        load_lw6();
        id_mem_read = 0; id_mem_to_reg = 0; id_src_imm = 0;
        id_rs = 6; id_rt = 1; id_rd = 7; id_ctrl_alu = 4'b0010;
        flush_ex = 1;
        #1;
        total++;
        if (stall_id !== 1'b0) $display("FAIL flush_stall: stall_id=%0b exp 0", stall_id);
        else passed++;
        step();
        total++;
        if ({ex_valid, ex_reg_write, ex_mem_read, ex_mem_to_reg} !== 4'b0 || ex_rd !== 5'd0 || ex_ctrl_alu !== 4'd0)
            $display("FAIL flush_bubble: valid=%0b rw=%0b rd=%0d ctrl=%h exp 0/0/0/0",
                     ex_valid, ex_reg_write, ex_rd, ex_ctrl_alu);
        else passed++;
        flush_ex = 0;
    endtask

    task automatic test_zero_and_shamt();
        clear_inputs();
        id_valid = 1; id_rs = 0; id_rt = 0; id_rd = 9; id_reg_write = 1;
        step();
        exmem_reg_write = 1; exmem_rd = 0; exmem_alu_out = 32'hFFFF;
        memwb_reg_write = 1; memwb_rd = 0; memwb_wdata = 32'hEEEE;
        #1;
        total++;
        if (ex_in1 !== 32'h0 || ex_in2 !== 32'h0)
            $display("FAIL zero_nofwd: in1=%h in2=%h exp 0", ex_in1, ex_in2);
        else passed++;
        clear_inputs();
        // sll $2,$3,3
        id_valid = 1; id_rt = 3; id_rt_data = 32'h5; id_rd = 2; id_shamt = 5'd3;
        id_src_shamt = 1; id_ctrl_alu = 4'b0100; id_reg_write = 1;
        step();
        total++;
        if (ex_in1 !== 32'h3 || ex_in2 !== 32'h5)
            $display("FAIL shamt: in1=%h in2=%h exp 00000003/00000005", ex_in1, ex_in2);
        else passed++;
    endtask

    task automatic test_capture_bypass();
        clear_inputs();
        id_valid = 1; id_rs = 9; id_rt = 9; id_rd = 10;
        id_rs_data = 32'h1; id_rt_data = 32'h2; id_imm = 32'h100; id_src_imm = 1;
        id_mem_write = 1;
        memwb_reg_write = 1; memwb_rd = 9; memwb_wdata = 32'hCAFE;
        step();
        memwb_reg_write = 0; memwb_rd = 0; memwb_wdata = 0;
        #1;
        total++;
        if (ex_in1 !== 32'hCAFE || ex_store_data !== 32'hCAFE)
            $display("FAIL capture_bypass: in1=%h st=%h exp 0000cafe", ex_in1, ex_store_data);
        else passed++;
        total++;
        if (ex_in2 !== 32'h100 || ex_mem_write !== 1'b1)
            $display("FAIL imm_select: in2=%h mw=%0b exp 00000100/1", ex_in2, ex_mem_write);
        else passed++;
    endtask

    initial begin
        passed = 0;
        total  = 0;
        clear_inputs();
        rst_n = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1;
        step();
        test_reset();
        test_exmem_fwd();
        test_fwd_priority();
        test_load_use();
        test_flush_over_stall();
        test_zero_and_shamt();
        test_capture_bypass();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
